// File: rtl/serial_subtractor_8b_if.sv
// rtl/serial_subtractor_8b_if.sv - start/done handshake bundle for the bit-serial subtractor
// Optional ovf signal is present only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_8b_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             zero;
  logic             busy;
  logic             done;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, bi,
    input  d, bo, zero, busy, done
`ifdef SERIAL_SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, bi,
    output d, bo, zero, busy, done
`ifdef SERIAL_SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_subtractor_8b.sv
// rtl/serial_subtractor_8b.sv - bit-serial a - b - bi subtractor, LSB first, one bit per clock
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor_8b #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_subtractor_8b_if.slave sub_if
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic [WIDTH-2:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, bo_q, zero_q;
  logic             accept, last, diff, br_d;
  logic [WIDTH-1:0] res_d;
  logic             busy, done;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, b_msb_q, ovf_q;
`endif

  assign accept = (state_q != RUN) && sub_if.start;
  assign last   = (cnt_q == LAST);
  assign diff   = a_q[0] ^ b_q[0] ^ br_q;
  assign br_d   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  // Difference bits enter at the MSB so the word is aligned after WIDTH shifts.
  assign res_d  = {diff, res_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sub_if.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = sub_if.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      br_q   <= 1'b0;
      d_q    <= '0;
      bo_q   <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept) begin
      a_q   <= sub_if.a;
      b_q   <= sub_if.b;
      br_q  <= sub_if.bi;
      res_q <= '0;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      br_q  <= br_d;
      res_q <= res_d[WIDTH-1:1];
      cnt_q <= cnt_q + CW'(1);
      // Visible results move only on the final bit, never mid-operation.
      if (last) begin
        d_q    <= res_d;
        bo_q   <= br_d;
        zero_q <= (res_d == '0);
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_msb_q <= sub_if.a[WIDTH-1];
      b_msb_q <= sub_if.b[WIDTH-1];
    end else if (state_q == RUN && last) begin
      ovf_q <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ res_d[WIDTH-1]);
    end
  end

  assign sub_if.ovf = ovf_q;
`endif

  assign sub_if.d    = d_q;
  assign sub_if.bo   = bo_q;
  assign sub_if.zero = zero_q;
  assign sub_if.busy = busy;
  assign sub_if.done = done;
endmodule
